cache_meta_store: RTL and testbench

- Parametrised metadata store for the M-stage set-associative cache.
- Holds per-line Valid, Dirty and Pending-To-Cache (PTC) bits, plus a per-line pending transaction ID and per-set true-LRU ages.
- Supersedes the fixed 4-set/4-way metadata store. Adds:
  - arbitrary sets and ways;
  - an ID-broadcast completion port that clears PTC in any set;
  - victim selection that prefers invalid ways.
- The cache controller reads set state combinationally and issues one line operation per cycle.

---
 rtl/cache_meta_pkg.sv | 35 +++
 rtl/cache_meta_line.sv | 62 ++++++
 rtl/cache_meta_store.sv | 150 +++++++++++++++
 tb/tb_cache_meta_store.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_meta_pkg.sv
// rtl/cache_meta_pkg.sv - shared types, op encoding and reset-age helper for cache_meta_store
package cache_meta_pkg;

    localparam int unsigned DEF_NUM_SETS = 4;
    localparam int unsigned DEF_NUM_WAYS = 4;
    localparam int unsigned DEF_ID_W     = 7;
    // Stored ID field is sized for the widest supported ID_W; narrower IDs are zero-extended.
    localparam int unsigned ID_W_MAX     = 16;

    typedef struct packed {
        logic                v;
        logic                d;
        logic                ptc;
        logic [ID_W_MAX-1:0] id;
    } line_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WB   = 2'd1,
        OP_SW   = 2'd2,
        OP_EX   = 2'd3
    } op_e;

    function automatic op_e op_decode(input logic ex, input logic sw, input logic wb);
        if (ex) return OP_EX;
        if (sw) return OP_SW;
        if (wb) return OP_WB;
        return OP_NONE;
    endfunction

    function automatic int unsigned reset_age(input int unsigned way_idx);
        return way_idx;
    endfunction

endpackage

// File: rtl/cache_meta_line.sv
// rtl/cache_meta_line.sv - one cache line's V/D/PTC/ID register with op and completion next-state
module cache_meta_line
    import cache_meta_pkg::*;
#(
    parameter int unsigned ID_W = DEF_ID_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sel,
    input  op_e             i_op,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_cmpl_valid,
    input  logic [ID_W-1:0] i_cmpl_id,
    input  logic            i_inv,
    output line_t           o_line
);

    line_t r_line;
    line_t w_next;

    // Completion is applied first so a same-cycle op on this line overrides it.
    always_comb begin
        w_next = r_line;
        if (i_cmpl_valid && r_line.v && r_line.ptc && (r_line.id == ID_W_MAX'(i_cmpl_id)))
            w_next.ptc = 1'b0;
        if (i_sel) begin
            case (i_op)
                OP_EX: begin
                    w_next.v   = 1'b1;
                    w_next.d   = 1'b0;
                    w_next.ptc = 1'b0;
                end
                OP_SW: begin
                    w_next.v   = 1'b1;
                    w_next.d   = 1'b1;
                    w_next.ptc = 1'b1;
                    w_next.id  = ID_W_MAX'(i_id);
                end
                OP_WB: begin
                    if (r_line.v)
                        w_next.d = 1'b0;
                end
                default: ;
            endcase
        end
        if (i_inv) begin
            w_next.v   = 1'b0;
            w_next.d   = 1'b0;
            w_next.ptc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_line <= '0;
        else
            r_line <= w_next;
    end

    assign o_line = r_line;

endmodule

// File: rtl/cache_meta_store.sv
// rtl/cache_meta_store.sv - set-associative metadata store with true-LRU and victim select; CACHE_META_INV_EN adds set invalidate
module cache_meta_store
    import cache_meta_pkg::*;
#(
    parameter  int unsigned NUM_SETS = DEF_NUM_SETS,
    parameter  int unsigned NUM_WAYS = DEF_NUM_WAYS,
    parameter  int unsigned ID_W     = DEF_ID_W,
    localparam int unsigned IDX_W    = $clog2(NUM_SETS),
    localparam int unsigned AGE_W    = $clog2(NUM_WAYS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [IDX_W-1:0]          index,
    input  logic [NUM_WAYS-1:0]       way,
    input  logic                      ex,
    input  logic                      sw,
    input  logic                      wb,
    input  logic [ID_W-1:0]           id_in,
    input  logic                      cmpl_valid,
    input  logic [ID_W-1:0]           cmpl_id,
`ifdef CACHE_META_INV_EN
    input  logic                      inv,
`endif
    output logic [NUM_WAYS-1:0]       valid_out,
    output logic [NUM_WAYS-1:0]       dirty_out,
    output logic [NUM_WAYS-1:0]       ptc_out,
    output logic [NUM_WAYS*AGE_W-1:0] lru_ages,
    output logic [NUM_WAYS-1:0]       victim
);

    line_t            w_line [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0] r_age  [NUM_SETS][NUM_WAYS];

    logic             w_touch;
    logic             w_inv;
    op_e              w_op;
    logic [AGE_W-1:0] w_tway;
    logic [AGE_W-1:0] w_told;

    assign w_touch = req_valid && (way != '0);
    assign w_op    = op_decode(ex, sw, wb);
`ifdef CACHE_META_INV_EN
    assign w_inv   = req_valid && inv;
`else
    assign w_inv   = 1'b0;
`endif

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            cache_meta_line #(.ID_W(ID_W)) u_line (
                .clk          (clk),
                .rst          (rst),
                .i_sel        (w_touch && (index == IDX_W'(s)) && way[w]),
                .i_op         (w_op),
                .i_id         (id_in),
                .i_cmpl_valid (cmpl_valid),
                .i_cmpl_id    (cmpl_id),
                .i_inv        (w_inv && (index == IDX_W'(s))),
                .o_line       (w_line[s][w])
            );
        end
    end

    always_comb begin
        w_tway = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++)
            if (way[w])
                w_tway = w_tway | AGE_W'(w);
    end

    assign w_told = r_age[index][w_tway];

    // Touch: the touched way becomes youngest, everything younger than it ages by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++)
                for (int unsigned w = 0; w < NUM_WAYS; w++)
                    r_age[s][w] <= AGE_W'(reset_age(w));
        end else if (w_inv) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++)
                r_age[index][w] <= AGE_W'(reset_age(w));
        end else if (w_touch) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (way[w])
                    r_age[index][w] <= '0;
                else if (r_age[index][w] < w_told)
                    r_age[index][w] <= r_age[index][w] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        valid_out = '0;
        dirty_out = '0;
        ptc_out   = '0;
        lru_ages  = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            valid_out[w]                = w_line[index][w].v;
            dirty_out[w]                = w_line[index][w].d;
            ptc_out[w]                  = w_line[index][w].ptc;
            lru_ages[w*AGE_W +: AGE_W]  = r_age[index][w];
        end
    end

    logic             w_have_inv;
    logic             w_have_np;
    logic [AGE_W-1:0] w_inv_way;
    logic [AGE_W-1:0] w_np_way;
    logic [AGE_W-1:0] w_np_age;
    logic [AGE_W-1:0] w_lru_way;

    // Invalid ways first, then the oldest non-pending way, else the plain LRU way.
    always_comb begin
        w_have_inv = 1'b0;
        w_have_np  = 1'b0;
        w_inv_way  = '0;
        w_np_way   = '0;
        w_np_age   = '0;
        w_lru_way  = '0;
        victim     = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_out[w]) begin
                w_have_inv = 1'b1;
                w_inv_way  = AGE_W'(w);
            end
        end
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (r_age[index][w] == AGE_W'(NUM_WAYS - 1))
                w_lru_way = AGE_W'(w);
            if (!ptc_out[w] && (!w_have_np || (r_age[index][w] > w_np_age))) begin
                w_have_np = 1'b1;
                w_np_age  = r_age[index][w];
                w_np_way  = AGE_W'(w);
            end
        end
        if (w_have_inv)
            victim[w_inv_way] = 1'b1;
        else if (w_have_np)
            victim[w_np_way] = 1'b1;
        else
            victim[w_lru_way] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && req_valid)
            assert ($onehot0(way));
    end

endmodule

// File: tb/tb_cache_meta_store.sv
// tb/tb_cache_meta_store.sv - scoreboard bench for cache_meta_store against a behavioural line/LRU model
module tb_cache_meta_store;

    localparam int NS = 4;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int IW = 7;
    localparam int XW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [XW-1:0] index;
    logic [NW-1:0] way;
    logic          ex, sw, wb;
    logic [IW-1:0] id_in;
    logic          cmpl_valid;
    logic [IW-1:0] cmpl_id;
`ifdef CACHE_META_INV_EN
    logic          inv;
`endif
    logic [NW-1:0]    valid_out, dirty_out, ptc_out, victim;
    logic [NW*AW-1:0] lru_ages;

    cache_meta_store #(.NUM_SETS(NS), .NUM_WAYS(NW), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .index      (index),
        .way        (way),
        .ex         (ex),
        .sw         (sw),
        .wb         (wb),
        .id_in      (id_in),
        .cmpl_valid (cmpl_valid),
        .cmpl_id    (cmpl_id),
`ifdef CACHE_META_INV_EN
        .inv        (inv),
`endif
        .valid_out  (valid_out),
        .dirty_out  (dirty_out),
        .ptc_out    (ptc_out),
        .lru_ages   (lru_ages),
        .victim     (victim)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic          m_v  [NS][NW];
    logic          m_d  [NS][NW];
    logic          m_p  [NS][NW];
    logic [IW-1:0] m_id [NS][NW];
    int            m_age[NS][NW];

    typedef struct {
        logic [NW-1:0]    v;
        logic [NW-1:0]    d;
        logic [NW-1:0]    p;
        logic [NW-1:0]    vic;
        logic [NW*AW-1:0] ages;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_v[s][w] = 0; m_d[s][w] = 0; m_p[s][w] = 0; m_id[s][w] = '0; m_age[s][w] = w;
            end
    endtask

    function automatic exp_t model_view(int s);
        exp_t e;
        int   pick = -1;
        e.v = '0; e.d = '0; e.p = '0; e.vic = '0; e.ages = '0;
        for (int w = 0; w < NW; w++) begin
            e.v[w] = m_v[s][w];
            e.d[w] = m_d[s][w];
            e.p[w] = m_p[s][w];
            e.ages[w*AW +: AW] = AW'(m_age[s][w]);
        end
        for (int w = 0; w < NW && pick < 0; w++)
            if (!m_v[s][w]) pick = w;
        for (int a = NW - 1; a >= 0 && pick < 0; a--)
            for (int w = 0; w < NW; w++)
                if (m_age[s][w] == a && !m_p[s][w]) pick = w;
        if (pick < 0)
            for (int w = 0; w < NW; w++)
                if (m_age[s][w] == NW - 1) pick = w;
        e.vic[pick] = 1'b1;
        return e;
    endfunction

    task automatic op(input int s, input logic [NW-1:0] wy, input logic e, input logic st, input logic b,
                      input logic [IW-1:0] id, input logic cv, input logic [IW-1:0] cid, input logic iv = 1'b0);
        int t, a;
        @(negedge clk);
        req_valid = 1; index = XW'(s); way = wy; ex = e; sw = st; wb = b;
        id_in = id; cmpl_valid = cv; cmpl_id = cid;
`ifdef CACHE_META_INV_EN
        inv = iv;
`endif
        if (cv)
            for (int i = 0; i < NS; i++)
                for (int w = 0; w < NW; w++)
                    if (m_v[i][w] && m_p[i][w] && m_id[i][w] == cid) m_p[i][w] = 0;
`ifdef CACHE_META_INV_EN
        if (iv) begin
            for (int w = 0; w < NW; w++) begin
                m_v[s][w] = 0; m_d[s][w] = 0; m_p[s][w] = 0; m_age[s][w] = w;
            end
        end else
`endif
        if (wy != '0) begin
            t = 0;
            for (int w = 0; w < NW; w++) if (wy[w]) t = w;
            if (e) begin
                m_v[s][t] = 1; m_d[s][t] = 0; m_p[s][t] = 0;
            end else if (st) begin
                m_v[s][t] = 1; m_d[s][t] = 1; m_p[s][t] = 1; m_id[s][t] = id;
            end else if (b && m_v[s][t]) begin
                m_d[s][t] = 0;
            end
            a = m_age[s][t];
            for (int w = 0; w < NW; w++) if (m_age[s][w] < a) m_age[s][w]++;
            m_age[s][t] = 0;
        end
        @(posedge clk);
        #1;
        req_valid = 0; cmpl_valid = 0; ex = 0; sw = 0; wb = 0; way = '0;
`ifdef CACHE_META_INV_EN
        inv = 0;
`endif
    endtask

    task automatic observe(input int s, input bit sync = 1'b1);
        exp_t          e;
        logic [NW-1:0] seen;
        if (sync) @(negedge clk);
        index = XW'(s);
        #1;
        sb.push_back(model_view(s));
        e = sb.pop_front();
        chk($sformatf("valid_s%0d", s), valid_out, e.v);
        chk($sformatf("dirty_s%0d", s), dirty_out, e.d);
        chk($sformatf("ptc_s%0d", s),   ptc_out,   e.p);
        chk($sformatf("ages_s%0d", s),  lru_ages,  e.ages);
        chk($sformatf("victim_s%0d", s), victim,   e.vic);
        seen = '0;
        for (int w = 0; w < NW; w++) seen[lru_ages[w*AW +: AW]] = 1'b1;
        chk($sformatf("perm_s%0d", s), seen, {NW{1'b1}});
    endtask

    initial begin
        rst = 1; req_valid = 0; index = '0; way = '0; ex = 0; sw = 0; wb = 0;
        id_in = '0; cmpl_valid = 0; cmpl_id = '0;
`ifdef CACHE_META_INV_EN
        inv = 0;
`endif
        model_reset();
        #3;
        for (int s = 0; s < NS; s++) observe(s, 1'b0);
        chk("reset_victim", victim, 4'b0001);
        @(negedge clk);
        rst = 0;

        // fill, store, completion and no-match completion on set 2
        op(2, 4'b0100, 1, 0, 0, 7'h00, 0, 7'h00);
        op(2, 4'b0100, 0, 1, 0, 7'h15, 0, 7'h00);
        observe(2);
        chk("store_ptc", ptc_out, 4'b0100);
        op(0, 4'b0000, 0, 0, 0, 7'h00, 1, 7'h15);
        observe(2);
        chk("cmpl_dirty_kept", dirty_out, 4'b0100);
        op(2, 4'b0100, 0, 1, 0, 7'h15, 0, 7'h00);
        op(0, 4'b0000, 0, 0, 0, 7'h00, 1, 7'h14);
        observe(2);
        op(2, 4'b0100, 0, 1, 0, 7'h22, 1, 7'h15);
        observe(2);
        chk("conflict_ptc", ptc_out, 4'b0100);
        op(1, 4'b0000, 0, 0, 0, 7'h00, 1, 7'h22);
        observe(2);
        op(2, 4'b0100, 0, 0, 1, 7'h00, 0, 7'h00);
        observe(2);

        // LRU ordering, pending-way skip and all-pending fallback on set 1
        for (int w = 0; w < NW; w++) op(1, NW'(1 << w), 1, 0, 0, 7'h00, 0, 7'h00);
        op(1, 4'b0001, 0, 0, 0, 7'h00, 0, 7'h00);
        op(1, 4'b0010, 0, 0, 0, 7'h00, 0, 7'h00);
        op(1, 4'b0100, 0, 0, 0, 7'h00, 0, 7'h00);
        op(1, 4'b1000, 0, 0, 0, 7'h00, 0, 7'h00);
        op(1, 4'b0001, 0, 0, 0, 7'h00, 0, 7'h00);
        observe(1);
        chk("lru_victim", victim, 4'b0010);
        op(1, 4'b1000, 0, 1, 0, 7'h03, 0, 7'h00);
        for (int w = 0; w < 3; w++) op(1, NW'(1 << w), 0, 0, 0, 7'h00, 0, 7'h00);
        observe(1);
        chk("ptc_skip_victim", victim, 4'b0001);
        for (int w = 0; w < 3; w++) op(1, NW'(1 << w), 0, 1, 0, 7'h05, 0, 7'h00);
        observe(1);
        chk("all_ptc_victim", victim, 4'b1000);
        op(3, 4'b0010, 0, 0, 1, 7'h00, 0, 7'h00);
        observe(3);

`ifdef CACHE_META_INV_EN
        op(1, 4'b0000, 0, 0, 0, 7'h00, 1, 7'h05, 1'b1);
        for (int w = 0; w < 3; w++) op(1, NW'(1 << w), 1, 0, 0, 7'h00, 0, 7'h00);
        observe(1);
        chk("inv_victim", victim, 4'b1000);
`endif

        // random traffic with small ID space so completions hit often
        for (int n = 0; n < 300; n++) begin
            int            s, r, k;
            logic [NW-1:0] wy;
            s  = $urandom_range(0, NS - 1);
            r  = $urandom_range(0, NW);
            wy = (r == NW) ? '0 : NW'(1 << r);
            k  = $urandom_range(0, 7);
            op(s, wy, k == 0, k == 1 || k == 2, k == 3 || k == 4, IW'($urandom_range(0, 3)),
               $urandom_range(0, 2) == 0, IW'($urandom_range(0, 3)));
            observe(s);
            if (n % 8 == 0) observe($urandom_range(0, NS - 1));
        end

        // asynchronous reset between edges with a request in flight
        @(negedge clk);
        req_valid = 1; index = 2'd1; way = 4'b0100; sw = 1; id_in = 7'h11;
        #1;
        rst = 1;
        model_reset();
        #1;
        req_valid = 0; way = '0; sw = 0;
        for (int s = 0; s < NS; s++) observe(s, 1'b0);
        chk("midrun_victim", victim, 4'b0001);
        @(negedge clk);
        rst = 0;
        observe(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
